muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multi-cycle multiply/divide unit that sits beside the single-cycle ALU and owns the HI/LO register pair. It decodes the R-type funct codes the ALU control does not handle (MULTU, DIVU, MTHI, MTLO) and sequences a 32-iteration shift-add or restoring-divide datapath. While an operation is in flight it signals `busy`, which the core uses to stall MFHI/MFLO and any further mult/div issue.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; sampled only on `clk` rising edge.
- `start`  in  1  issue strobe; qualifies `funct`, `rs_data`, `rt_data` this cycle.
- `funct`  in  6  R-type function field: 6'h19 MULTU, 6'h1B DIVU, 6'h11 MTHI, 6'h13 MTLO; others ignored.
- `rs_data`  in  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- `rt_data`  in  WIDTH  multiplier/divisor.
- `busy`  out  1  high while an iterative op runs.
- `done`  out  1  one-cycle pulse when HI/LO hold a new mult/div result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset (reset==0 at an edge) forces IDLE, counter=0, hi=0, lo=0, internal operand regs=0, busy=0, done=0. This also applies mid-operation; the partial result is discarded.
- An issue is accepted only in IDLE or DONE with `start`=1:
  - MULTU: latch `rs_data` as multiplicand M, load {hi,lo}={0, rt_data}, counter=0, go to MUL.
  - DIVU: latch `rt_data` as divisor D, load {hi,lo}={0, rs_data}, counter=0, go to DIV.
  - MTHI/MTLO: write `hi`/`lo` from `rs_data` at that edge, then go to IDLE; no busy, no done.
  - Any other funct: no effect, go to IDLE.
- In MUL/DIV, `start` is ignored entirely. No queuing; the core must not issue while busy.
- MUL iteration: sum[WIDTH:0] = {1'b0,hi} + (lo[0] ? M : 0); {hi,lo} <= {sum, lo[WIDTH-1:1]}, i.e. a 2·WIDTH+1-bit right shift dropping the lsb. The carry enters hi msb.
- DIV iteration (restoring): shifted = {hi,lo} << 1; diff[WIDTH:0] = {1'b0,shifted_hi} − {1'b0,D}. If diff[WIDTH]==0, hi<=diff[WIDTH-1:0] and lo<=shifted_lo|1. Otherwise hi<=shifted_hi and lo<=shifted_lo. Final state: lo=quotient, hi=remainder.
- Divide by zero is not trapped. It yields lo={WIDTH{1'b1}} and hi=dividend, which falls out of the algorithm.
- The counter increments each iteration. The iteration with counter==WIDTH−1 is the last one; the next state is DONE.
- DONE lasts one cycle with done=1. Without a new issue it returns to IDLE.
- All arithmetic is unsigned and modulo its stated width. No signed MULT/DIV.

## Timing
- Issue edge = cycle 0. busy=1 in cycles 1..WIDTH (32 cycles). The final HI/LO value is written at the end of cycle WIDTH. done=1 and busy=0 in cycle WIDTH+1 (33). Latency from start to done is 33 cycles.
- `hi`/`lo` are registered. During MUL/DIV they show intermediate values, and consumers must wait for !busy.
- A start in the DONE cycle is accepted, so back-to-back ops are spaced 33 cycles apart.
- MTHI/MTLO take effect on the edge they are issued and are visible the next cycle.
- Simultaneous reset and start: reset wins.

## Structure
- Shared package `muldiv_pkg`: funct localparams (FUNCT_MULTU, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO) and the 2-bit state encoding (IDLE=0, MUL=1, DIV=2, DONE=3).
- One sub-module, `muldiv_addsub`: a WIDTH+1-bit combinational adder/subtractor (sub select, carry/borrow out), shared by MUL and DIV.
- Counter width is $clog2(WIDTH).

## Test plan
- MULTU 7×6 → busy high cycles 1–32; done in cycle 33 with hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 at done.
- DIVU 100/7 → lo=0x0000000E, hi=0x00000002 at done; then 5/0 → lo=0xFFFFFFFF, hi=0x00000005.
- MULTU 3×3 issued, then start with DIVU 9/2 in cycle 5 → second start ignored; result hi=0, lo=9; a DIVU issued in the DONE cycle gives lo=4, hi=1 33 cycles later.
- MTHI 0x12345678 then MTLO 0xCAFEBABE → hi/lo updated the next cycle each; busy and done stay 0.
- MULTU 0x10000×0x10000, reset low in cycle 10 → next cycle hi=lo=0, busy=0, and done never pulses.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes and state encoding shared by the mult/div sequencer
package muldiv_pkg;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: WIDTH+1-bit adder/subtractor; y[WIDTH] is carry on add, borrow on sub
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   y
);
  assign y = {1'b0, a} + ({1'b0, b} ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULTU/DIVU unit owning HI/LO, plus MTHI/MTLO writes
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             is_div, running;
  logic [WIDTH-1:0] sh_hi, as_a, as_b;
  logic [WIDTH:0]   sum;
  assign is_div  = state_q == S_DIV;
  assign running = (state_q == S_MUL) || is_div;
  assign sh_hi   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign as_a    = is_div ? sh_hi : hi_q;
  assign as_b    = (is_div || lo_q[0]) ? opnd_q : '0;
  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a  (as_a),
    .b  (as_b),
    .sub(is_div),
    .y  (sum)
  );
  // opnd holds the multiplicand in MUL and the divisor in DIV
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    if (running) begin
      hi_d    = is_div ? (sum[WIDTH] ? sh_hi : sum[WIDTH-1:0]) : sum[WIDTH:1];
      lo_d    = is_div ? {lo_q[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH-1)) ? S_DONE : state_q;
    end else begin
      state_d = S_IDLE;
      if (start) begin
        case (funct)
          FUNCT_MULTU: begin
            opnd_d  = rs_data;
            hi_d    = '0;
            lo_d    = rt_data;
            cnt_d   = '0;
            state_d = S_MUL;
          end
          FUNCT_DIVU: begin
            opnd_d  = rt_data;
            hi_d    = '0;
            lo_d    = rs_data;
            cnt_d   = '0;
            state_d = S_DIV;
          end
          FUNCT_MTHI: hi_d = rs_data;
          FUNCT_MTLO: lo_d = rs_data;
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
    end
  end
  assign busy = running;
  assign done = state_q == S_DONE;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random MULTU/DIVU/MTHI/MTLO checks against an arithmetic model
module tb_muldiv_sequencer;
  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [5:0]  funct = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          errors = 0, checks = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (f == 6'h19) begin
      p = {32'd0, a} * {32'd0, b};
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (f == 6'h1B) begin
      m_hi = (b == 0) ? a : a % b;
      m_lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
    end else if (f == 6'h11) m_hi = a;
    else if (f == 6'h13) m_lo = a;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1; funct = f; rs_data = a; rt_data = b;
    tick();
    start = 0; funct = 0; rs_data = $urandom; rt_data = $urandom;
  endtask

  // Issues a mult/div and follows it to the done cycle; glitch_cyc>0 drives a stray DIVU then.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int glitch_cyc);
    int n, nb;
    issue(f, a, b);
    model(f, a, b);
    n = 0; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (n + 1 == glitch_cyc) begin
        start = 1; funct = 6'h1B; rs_data = 9; rt_data = 2;
      end
      tick();
      start = 0;
      n++;
    end
    chk({tag, " busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, " latency"}, 64'(n + 1), 64'd33);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(m_hi));
    chk({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    tick(); tick();
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    reset = 1;
    tick();

    run_op("mul7x6", 6'h19, 7, 6, 0);
    chk("mul7x6 lo_const", 64'(lo), 64'h2A);
    tick();
    chk("done_pulse_fall", 64'(done), 64'd0);
    run_op("mulmax", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("mulmax hi_const", 64'(hi), 64'hFFFF_FFFE);
    tick();
    run_op("div100_7", 6'h1B, 100, 7, 0);
    chk("div100_7 const", {hi, lo}, {32'd2, 32'd14});
    tick();
    run_op("div5_0", 6'h1B, 5, 0, 0);
    chk("div5_0 const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    tick();

    run_op("mul3x3_glitch", 6'h19, 3, 3, 5);
    chk("mul3x3 const", {hi, lo}, {32'd0, 32'd9});
    run_op("div9_2_b2b", 6'h1B, 9, 2, 0);
    chk("div9_2 const", {hi, lo}, {32'd1, 32'd4});
    tick();

    issue(6'h11, 32'h1234_5678, 0);
    model(6'h11, 32'h1234_5678, 0);
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    chk("mthi busy_done", {62'd0, busy, done}, 64'd0);
    issue(6'h13, 32'hCAFE_BABE, 0);
    model(6'h13, 32'hCAFE_BABE, 0);
    chk("mtlo lo", 64'(lo), 64'hCAFE_BABE);
    chk("mtlo hi_kept", 64'(hi), 64'h1234_5678);
    chk("mtlo busy_done", {62'd0, busy, done}, 64'd0);

    issue(6'h19, 32'h1_0000, 32'h1_0000);
    for (int i = 1; i < 10; i++) tick();
    reset = 0;
    tick();
    reset = 1;
    chk("midrst hilo", {hi, lo}, 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    m_hi = 0; m_lo = 0;
    begin
      int pulses = 0;
      for (int i = 0; i < 40; i++) begin
        if (done) pulses++;
        tick();
      end
      chk("midrst no_done", 64'(pulses), 64'd0);
    end

    for (int k = 0; k < 24; k++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      int sel = $urandom_range(0, 5);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (sel < 2) a = a >> $urandom_range(0, 31);
      if (sel <= 1) run_op("rnd_mul", 6'h19, a, b, ($urandom_range(0, 3) == 0) ? 7 : 0);
      else if (sel <= 3) run_op("rnd_div", 6'h1B, a, b, 0);
      else begin
        f = (sel == 4) ? (($urandom_range(0, 1) == 1) ? 6'h11 : 6'h13) : 6'h20;
        issue(f, a, b);
        model(f, a, b);
        chk("rnd_mt hilo", {hi, lo}, {m_hi, m_lo});
        chk("rnd_mt busy", 64'(busy), 64'd0);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
